pcie_tx_pkt_arbiter: RTL

- Packet-granular round-robin arbiter that merges NUM_SRC AXI-S TLP streams from AFU workloads onto one PCIe TX port (TX A or TX B) of a PR slot port.
- Sits between exerciser instances and the per-port TX pipeline stage.
- Never interleaves beats of different packets. Supports a configurable packet burst per grant.

---
 rtl/pcie_tx_pkt_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/pcie_tx_pkt_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_SRC AXI-S TLP streams onto one PCIe TX port.
// Define PCIE_TX_ARB_STATS_EN to add per-source completed-packet counters (stat_clr / stat_pkt_cnt).
module pcie_tx_pkt_arbiter #(
  parameter int NUM_SRC            = 3,
  parameter int TDATA_WIDTH        = 512,
  parameter int TUSER_WIDTH        = 10,
  parameter int MAX_PKTS_PER_GRANT = 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_SRC-1:0]               s_tvalid,
  output logic [NUM_SRC-1:0]               s_tready,
  input  logic [NUM_SRC*TDATA_WIDTH-1:0]   s_tdata,
  input  logic [NUM_SRC*TDATA_WIDTH/8-1:0] s_tkeep,
  input  logic [NUM_SRC*TUSER_WIDTH-1:0]   s_tuser,
  input  logic [NUM_SRC-1:0]               s_tlast,
  output logic                             m_tvalid,
  input  logic                             m_tready,
  output logic [TDATA_WIDTH-1:0]           m_tdata,
  output logic [TDATA_WIDTH/8-1:0]         m_tkeep,
  output logic [TUSER_WIDTH-1:0]           m_tuser,
  output logic                             m_tlast,
  output logic [$clog2(NUM_SRC)-1:0]       grant_idx,
  output logic                             busy
`ifdef PCIE_TX_ARB_STATS_EN
  ,
  input  logic                             stat_clr,
  output logic [NUM_SRC*32-1:0]            stat_pkt_cnt
`endif
);
  localparam int               IDX_W     = $clog2(NUM_SRC);
  localparam int               KEEP_W    = TDATA_WIDTH / 8;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_SRC - 1);
  localparam logic [7:0]       BURST_END = 8'(MAX_PKTS_PER_GRANT - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_grant, w_grant_nxt;
  logic [7:0]         r_burst, w_burst_nxt;
  logic               r_eop, w_eop_nxt;
  logic [NUM_SRC-1:0] w_sel;
  logic               w_vld, w_last, w_hs;
  logic               w_found;
  logic [IDX_W-1:0]   w_pick, w_probe;

  // Output mux driven by the registered grant: zero-latency path from the owning source.
  always_comb begin
    w_sel   = '0;
    w_vld   = 1'b0;
    w_last  = 1'b0;
    m_tdata = '0;
    m_tkeep = '0;
    m_tuser = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (r_grant == IDX_W'(k)) begin
        w_sel[k] = 1'b1;
        w_vld    = s_tvalid[k];
        w_last   = s_tlast[k];
        m_tdata  = s_tdata[k*TDATA_WIDTH +: TDATA_WIDTH];
        m_tkeep  = s_tkeep[k*KEEP_W +: KEEP_W];
        m_tuser  = s_tuser[k*TUSER_WIDTH +: TUSER_WIDTH];
      end
    end
  end

  assign busy      = (r_state == S_GRANT);
  assign grant_idx = r_grant;
  assign m_tvalid  = busy & w_vld;
  assign m_tlast   = w_last;
  assign s_tready  = busy ? (w_sel & {NUM_SRC{m_tready}}) : '0;
  assign w_hs      = m_tvalid & m_tready;

  // Rotating search starting one past the last grant; NUM_SRC need not be a power of two.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_grant;
    w_probe = r_grant;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_probe = (w_probe == LAST_IDX) ? '0 : w_probe + 1'b1;
      if (!w_found && s_tvalid[w_probe]) begin
        w_found = 1'b1;
        w_pick  = w_probe;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_burst_nxt = r_burst;
    w_eop_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_grant_nxt = w_pick;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (w_hs && w_last) begin
          if (r_burst == BURST_END) begin
            w_burst_nxt = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_burst_nxt = r_burst + 8'd1;
            w_eop_nxt   = 1'b1;
          end
        end else if (r_eop && !w_vld) begin
          // Source has nothing queued right after its packet: release early.
          w_burst_nxt = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_grant <= LAST_IDX;
      r_burst <= '0;
      r_eop   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_burst <= w_burst_nxt;
      r_eop   <= w_eop_nxt;
    end
  end

`ifdef PCIE_TX_ARB_STATS_EN
  logic [31:0] r_pkt_cnt [NUM_SRC];

  // Clear wins over a coincident increment; counts saturate at all-ones.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!rst_n || stat_clr) begin
        r_pkt_cnt[k] <= '0;
      end else if (w_hs && w_last && w_sel[k] && (r_pkt_cnt[k] != 32'hFFFF_FFFF)) begin
        r_pkt_cnt[k] <= r_pkt_cnt[k] + 32'd1;
      end
    end
  end

  always_comb begin
    stat_pkt_cnt = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      stat_pkt_cnt[k*32 +: 32] = r_pkt_cnt[k];
    end
  end
`endif

endmodule
